// File: rtl/de270_dct_pkg.sv
// -----------------------------------------------------------------------------
// de270_dct_pkg
// Shared constants, types and helpers for the OCI debug compressed-trace (DCT)
// buffer controller.
//   ATOM_W  : bits per trace atom
//   DEPTH   : atoms per buffer (buffer width BUF_W = ATOM_W*DEPTH)
//   CNT_W   : occupancy count width, must hold DEPTH
//   OVF_W   : dropped-atom counter width
//   TIMEOUT : idle cycles before auto-flush (used only with DE270_DCT_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package de270_dct_pkg;

  localparam int ATOM_W  = 2;
  localparam int DEPTH   = 15;
  localparam int CNT_W   = 4;
  localparam int BUF_W   = ATOM_W * DEPTH;
  localparam int OVF_W   = 8;
  localparam int TIMEOUT = 255;
  localparam int TMR_W   = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2,
    ENDED = 2'd3
  } state_e;

  typedef logic [ATOM_W-1:0] atom_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [BUF_W-1:0]  buf_t;
  typedef logic [OVF_W-1:0]  ovf_t;
  typedef logic [TMR_W-1:0]  tmr_t;

  // Return buffer b with atom a written into slot (atom i lives in [2i+1:2i]).
  function automatic buf_t put_atom(input buf_t b, input cnt_t slot, input atom_t a);
    buf_t r;
    r = b;
    r[int'(slot)*ATOM_W +: ATOM_W] = a;
    return r;
  endfunction

endpackage

// File: rtl/de270_dct_idle_timer.sv
// -----------------------------------------------------------------------------
// de270_dct_idle_timer
// Counts idle cycles of a partially filled buffer and flags when the
// TIMEOUT-th consecutive idle cycle is being sampled, so the controller can
// flush on that same edge.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   run_i      : idle cycle (ACCUM, count>0, no atom)
//   clear_i    : restart the count (atom accepted or buffer emitted)
//   expired_o  : this idle cycle is the TIMEOUT-th one
// Only instantiated when DE270_DCT_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module de270_dct_idle_timer
  import de270_dct_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  tmr_t timer_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else if (clear_i) begin
      timer_q <= '0;
    end else if (run_i && (timer_q != '1)) begin
      timer_q <= timer_q + tmr_t'(1);
    end
  end

  assign expired_o = run_i && (timer_q == tmr_t'(TIMEOUT - 1));

endmodule

// File: rtl/de270_cpu_oci_dct_ctrl.sv
// -----------------------------------------------------------------------------
// de270_cpu_oci_dct_ctrl
// Packs 2-bit trace atoms into a 15-atom buffer, emits full or flushed
// buffers over a valid/ready handshake, and drains the partial buffer at
// end of test.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   atom_valid/data   : incoming trace atom
//   atom_ready        : atoms accepted this cycle (ACCUM only)
//   flush_req         : pulse, emit partial buffer if non-empty
//   test_ending       : level, start end-of-test drain
//   dct_valid/ready   : buffer handshake to the trace-memory writer
//   dct_buffer/count  : emitted atoms and number of valid atoms (1..15)
//   ovf_count         : saturating count of atoms dropped while emitting
//   test_has_ended    : sticky drain-complete flag
// Optional build macro: DE270_DCT_TIMEOUT_EN adds an idle auto-flush timer.
// -----------------------------------------------------------------------------
module de270_cpu_oci_dct_ctrl
  import de270_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  input  logic              flush_req,
  input  logic              test_ending,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic [OVF_W-1:0]  ovf_count,
  output logic              test_has_ended
);

  state_e state_q;
  buf_t   buf_q, dct_buffer_q;
  cnt_t   cnt_q, dct_count_q;
  ovf_t   ovf_q;
  logic   atom_ready_q, dct_valid_q, ended_q;

  logic   accept, emit_now, tmo_expired;
  buf_t   buf_d;
  cnt_t   cnt_d;

  // Next buffer/count include a same-cycle atom so that fill, flush and
  // end-of-test all see the atom accepted on the emitting edge.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept   = 1'b0;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    emit_now = 1'b0;
    if (state_q == ACCUM) begin
      accept = atom_valid;
      if (accept) begin
        buf_d = put_atom(buf_q, cnt_q, atom_data);
        cnt_d = cnt_q + cnt_t'(1);
      end
      emit_now = (cnt_d != '0) &&
                 ((cnt_d == cnt_t'(DEPTH)) || flush_req || tmo_expired);
    end
  end

`ifdef DE270_DCT_TIMEOUT_EN
  de270_dct_idle_timer u_idle_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     ((state_q == ACCUM) && (cnt_q != '0) && !atom_valid),
    .clear_i   (accept || (state_q != ACCUM)),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      atom_ready_q <= 1'b1;
      dct_valid_q  <= 1'b0;
      dct_buffer_q <= '0;
      dct_count_q  <= '0;
      ovf_q        <= '0;
      ended_q      <= 1'b0;
      buf_q        <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          buf_q <= buf_d;
          cnt_q <= cnt_d;
          if (test_ending) begin
            atom_ready_q <= 1'b0;
            if (cnt_d != '0) begin
              dct_buffer_q <= buf_d;
              dct_count_q  <= cnt_d;
              dct_valid_q  <= 1'b1;
              state_q      <= DRAIN;
            end else begin
              ended_q <= 1'b1;
              state_q <= ENDED;
            end
          end else if (emit_now) begin
            dct_buffer_q <= buf_d;
            dct_count_q  <= cnt_d;
            dct_valid_q  <= 1'b1;
            atom_ready_q <= 1'b0;
            state_q      <= EMIT;
          end
        end
        EMIT, DRAIN: begin
          if (atom_valid && (ovf_q != '1)) begin
            ovf_q <= ovf_q + ovf_t'(1);
          end
          if (dct_ready) begin
            dct_valid_q <= 1'b0;
            buf_q       <= '0;
            cnt_q       <= '0;
            // With the buffer now empty, a pending test_ending ends directly.
            if ((state_q == DRAIN) || test_ending) begin
              ended_q <= 1'b1;
              state_q <= ENDED;
            end else begin
              atom_ready_q <= 1'b1;
              state_q      <= ACCUM;
            end
          end
        end
        ENDED: ;
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign atom_ready     = atom_ready_q;
  assign dct_valid      = dct_valid_q;
  assign dct_buffer     = dct_buffer_q;
  assign dct_count      = dct_count_q;
  assign ovf_count      = ovf_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_de270_cpu_oci_dct_ctrl.sv
module tb_de270_cpu_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush_req;
  logic        test_ending;
  logic        dct_valid;
  logic        dct_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  ovf_count;
  logic        test_has_ended;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de270_cpu_oci_dct_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .ovf_count      (ovf_count),
    .test_has_ended (test_has_ended)
  );

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    atom_valid = 0; atom_data = 0; flush_req = 0; test_ending = 0; dct_ready = 0;
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic send_atom(input logic [1:0] a);
    atom_valid = 1; atom_data = a;
    cycle();
    atom_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (atom_ready !== 1'b1) begin errors++; $display("FAIL reset_atom_ready got %b exp 1", atom_ready); end
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL reset_dct_valid got %b exp 0", dct_valid); end
    checks++; if (dct_buffer !== 30'h0) begin errors++; $display("FAIL reset_dct_buffer got %h exp 0", dct_buffer); end
    checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL reset_dct_count got %0d exp 0", dct_count); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", ovf_count); end
    checks++; if (test_has_ended !== 1'b0) begin errors++; $display("FAIL reset_ended got %b exp 0", test_has_ended); end
  endtask

  // Fill 15 atoms with a repeating pattern starting at 'first' and cycling over 'span' values.
  task automatic test_fill(input int first, input int span, input logic [29:0] exp_buf);
    do_reset();
    dct_ready = 1;
    for (int i = 0; i < 14; i++) begin
      send_atom(2'((i % span) + first));
      checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid atom %0d got %b exp 0", i, dct_valid); end
    end
    send_atom(2'((14 % span) + first));
    checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", dct_valid); end
    checks++; if (dct_count !== 4'd15) begin errors++; $display("FAIL fill_count got %0d exp 15", dct_count); end
    checks++; if (dct_buffer !== exp_buf) begin errors++; $display("FAIL fill_buffer got %h exp %h", dct_buffer, exp_buf); end
    checks++; if (atom_ready !== 1'b0) begin errors++; $display("FAIL fill_atom_ready got %b exp 0", atom_ready); end
    cycle();
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_drop got %b exp 0", dct_valid); end
    checks++; if (atom_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back got %b exp 1", atom_ready); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL fill_ovf got %0d exp 0", ovf_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 15; i++) send_atom(2'd2);
    atom_valid = 1; atom_data = 2'd1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (dct_buffer !== 30'h2AAAAAAA || dct_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d got v=%b buf=%h exp v=1 buf=2aaaaaaa", i, dct_valid, dct_buffer); end
    end
    checks++; if (ovf_count !== 8'd10) begin errors++; $display("FAIL bp_ovf got %0d exp 10", ovf_count); end
    atom_valid = 0; dct_ready = 1;
    cycle();
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b exp 0", dct_valid); end
    checks++; if (atom_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", atom_ready); end
    checks++; if (ovf_count !== 8'd10) begin errors++; $display("FAIL bp_ovf_after got %0d exp 10", ovf_count); end
  endtask

  task automatic test_ovf_saturate();
    do_reset();
    for (int i = 0; i < 15; i++) send_atom(2'd0);
    atom_valid = 1;
    for (int i = 0; i < 260; i++) cycle();
    atom_valid = 0;
    checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL ovf_saturate got %0d exp 255", ovf_count); end
  endtask

  task automatic test_flush();
    do_reset();
    send_atom(2'd3); send_atom(2'd3); send_atom(2'd1);
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL flush_pre_valid got %b exp 0", dct_valid); end
    flush_req = 1; cycle(); flush_req = 0;
    checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", dct_valid); end
    checks++; if (dct_count !== 4'd3) begin errors++; $display("FAIL flush_count got %0d exp 3", dct_count); end
    checks++; if (dct_buffer !== 30'h1F) begin errors++; $display("FAIL flush_buffer got %h exp 1f", dct_buffer); end
    dct_ready = 1; cycle();
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b exp 0", dct_valid); end
    flush_req = 1; cycle(); flush_req = 0;
    cycle();
    checks++; if (dct_valid !== 1'b0 || atom_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got v=%b r=%b exp v=0 r=1", dct_valid, atom_ready); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 13; i++) send_atom(2'd1);
    atom_valid = 1; atom_data = 2'd1; flush_req = 1;
    cycle();
    atom_valid = 0; flush_req = 0;
    checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd14) begin errors++; $display("FAIL same14_emit got v=%b cnt=%0d exp v=1 cnt=14", dct_valid, dct_count); end
    checks++; if (dct_buffer !== 30'h05555555) begin errors++; $display("FAIL same14_buffer got %h exp 05555555", dct_buffer); end
    dct_ready = 1; cycle();
    cycle();
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL same14_single got %b exp 0", dct_valid); end
    dct_ready = 0;
    for (int i = 0; i < 14; i++) send_atom(2'd2);
    atom_valid = 1; atom_data = 2'd2; flush_req = 1;
    cycle();
    atom_valid = 0; flush_req = 0;
    checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd15) begin errors++; $display("FAIL same15_emit got v=%b cnt=%0d exp v=1 cnt=15", dct_valid, dct_count); end
    dct_ready = 1; cycle();
    cycle();
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL same15_single got %b exp 0", dct_valid); end
  endtask

  task automatic test_reset_mid_emit();
    do_reset();
    for (int i = 0; i < 15; i++) send_atom(2'd3);
    checks++; if (dct_valid !== 1'b1) begin errors++; $display("FAIL rst_emit_setup got %b exp 1", dct_valid); end
    reset = 1; cycle(); reset = 0;
    checks++; if (dct_valid !== 1'b0 || dct_count !== 4'd0 || atom_ready !== 1'b1) begin errors++; $display("FAIL rst_emit_state got v=%b cnt=%0d r=%b exp v=0 cnt=0 r=1", dct_valid, dct_count, atom_ready); end
    atom_valid = 1; atom_data = 2'd2; flush_req = 1;
    cycle();
    atom_valid = 0; flush_req = 0;
    checks++; if (dct_count !== 4'd1 || dct_buffer !== 30'h2) begin errors++; $display("FAIL rst_emit_cleared got cnt=%0d buf=%h exp cnt=1 buf=2", dct_count, dct_buffer); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_atom(2'd1);
`ifdef DE270_DCT_TIMEOUT_EN
    for (int i = 1; i < 255; i++) begin
      cycle();
      checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL tmo_early cyc %0d got %b exp 0", i, dct_valid); end
    end
    cycle();
    checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd1) begin errors++; $display("FAIL tmo_emit got v=%b cnt=%0d exp v=1 cnt=1", dct_valid, dct_count); end
`else
    for (int i = 0; i < 300; i++) cycle();
    checks++; if (dct_valid !== 1'b0) begin errors++; $display("FAIL no_tmo_emit got %b exp 0", dct_valid); end
    flush_req = 1; cycle(); flush_req = 0;
    checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd1) begin errors++; $display("FAIL no_tmo_flush got v=%b cnt=%0d exp v=1 cnt=1", dct_valid, dct_count); end
`endif
  endtask

  task automatic test_end_of_test();
    do_reset();
    for (int i = 0; i < 5; i++) send_atom(2'd3);
    test_ending = 1;
    cycle();
    checks++; if (dct_valid !== 1'b1 || dct_count !== 4'd5) begin errors++; $display("FAIL eot_emit got v=%b cnt=%0d exp v=1 cnt=5", dct_valid, dct_count); end
    checks++; if (dct_buffer !== 30'h3FF) begin errors++; $display("FAIL eot_buffer got %h exp 3ff", dct_buffer); end
    checks++; if (test_has_ended !== 1'b0) begin errors++; $display("FAIL eot_early_end got %b exp 0", test_has_ended); end
    dct_ready = 1;
    cycle();
    checks++; if (test_has_ended !== 1'b1 || dct_valid !== 1'b0 || atom_ready !== 1'b0) begin errors++; $display("FAIL eot_ended got e=%b v=%b r=%b exp e=1 v=0 r=0", test_has_ended, dct_valid, atom_ready); end
    test_ending = 0; atom_valid = 1; flush_req = 1;
    for (int i = 0; i < 6; i++) cycle();
    atom_valid = 0; flush_req = 0;
    checks++; if (test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin errors++; $display("FAIL eot_sticky got e=%b v=%b exp e=1 v=0", test_has_ended, dct_valid); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL eot_ovf got %0d exp 0", ovf_count); end
    // Empty buffer at test end goes straight to ENDED without an emit.
    do_reset();
    test_ending = 1;
    cycle();
    checks++; if (test_has_ended !== 1'b1 || dct_valid !== 1'b0) begin errors++; $display("FAIL eot_empty got e=%b v=%b exp e=1 v=0", test_has_ended, dct_valid); end
    test_ending = 0;
  endtask

  initial begin
    reset = 1; atom_valid = 0; atom_data = 0; flush_req = 0; test_ending = 0; dct_ready = 0;
    test_reset();
    test_fill(0, 4, 30'h24E4E4E4);
    test_fill(1, 3, 30'h39E79E79);
    test_backpressure();
    test_ovf_saturate();
    test_flush();
    test_same_cycle();
    test_reset_mid_emit();
    test_timeout();
    test_end_of_test();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
